// File: rtl/arch_reg_read_responder.sv
// arch_reg_read_responder
// Debug-side reader of architectural registers. A request carries an
// architectural index. The index goes through the RAT to find the physical
// register, and the physical regfile is then read through a shared, arbitrated
// read port. The value comes back with a one-cycle read_valid pulse.
//
// Handshake contract:
//   request  : the initiator holds rd_en (and read_red_addr_req) until it sees
//              read_valid. The request is accepted only on an edge where both
//              rd_en and quiesced are high.
//   response : read_valid is high for exactly one cycle, and read_value is
//              valid in that cycle. After the pulse the block ignores rd_en
//              until the initiator has dropped it for at least one edge.
//   prf port : prf_req and prf_addr stay stable until prf_gnt is sampled high
//              at an edge. prf_rdata is sampled on the edge that follows the
//              grant edge.
module arch_reg_read_responder #(
  parameter int ARCH_REG_NUM       = 32,
  parameter int ARCH_REG_NUM_WIDTH = 5,
  parameter int PHYS_REG_NUM_WIDTH = 6,
  parameter int REG_VAL_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          quiesced,
  input  logic                          rd_en,
  input  logic [ARCH_REG_NUM_WIDTH-1:0] read_red_addr_req,
  output logic                          read_valid,
  output logic [REG_VAL_WIDTH-1:0]      read_value,
  output logic [ARCH_REG_NUM_WIDTH-1:0] rat_arch_idx,
  input  logic [PHYS_REG_NUM_WIDTH-1:0] rat_phys_idx,
  output logic                          prf_req,
  output logic [PHYS_REG_NUM_WIDTH-1:0] prf_addr,
  input  logic                          prf_gnt,
  input  logic [REG_VAL_WIDTH-1:0]      prf_rdata,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAT      = 3'd1,
    S_PRF_REQ  = 3'd2,
    S_PRF_DATA = 3'd3,
    S_RESP     = 3'd4,
    S_DROP     = 3'd5
  } state_t;

  state_t                          state;
  logic [ARCH_REG_NUM_WIDTH-1:0]   idx_q;
  logic [PHYS_REG_NUM_WIDTH-1:0]   phys_q;

  // x0 reads as zero. An index past the register file also returns zero
  // without touching the RAT or the PRF.
  logic zero_path;
  assign zero_path = (read_red_addr_req == '0) ||
                     (32'(read_red_addr_req) >= ARCH_REG_NUM);

  // The RAT index and the PRF address come straight from the latched registers,
  // so they are stable for the whole of the state that uses them.
  assign rat_arch_idx = idx_q;
  assign prf_addr     = phys_q;
  assign dbg_state    = state;

  // Request FSM. The read_valid pulse is produced on the edge that leaves RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx_q      <= '0;
      phys_q     <= '0;
      prf_req    <= 1'b0;
      read_valid <= 1'b0;
      read_value <= '0;
    end else begin
      read_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_en && quiesced) begin
            idx_q <= read_red_addr_req;
            if (zero_path) begin
              read_value <= '0;
              state      <= S_RESP;
            end else begin
              state <= S_RAT;
            end
          end
        end
        S_RAT: begin
          phys_q  <= rat_phys_idx;
          prf_req <= 1'b1;
          state   <= S_PRF_REQ;
        end
        S_PRF_REQ: begin
          if (prf_gnt) begin
            prf_req <= 1'b0;
            state   <= S_PRF_DATA;
          end
        end
        S_PRF_DATA: begin
          read_value <= prf_rdata;
          state      <= S_RESP;
        end
        S_RESP: begin
          read_valid <= 1'b1;
          state      <= S_DROP;
        end
        S_DROP: begin
          if (!rd_en) state <= S_IDLE;
        end
        default: begin
          prf_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arch_reg_read_responder.sv
// Directed bench for arch_reg_read_responder. It contains small behavioural
// models of the RAT (combinational lookup) and of the arbitrated PRF port
// (grant after a programmable number of stall cycles, data one cycle after the
// grant edge).
module tb_arch_reg_read_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        quiesced;
  logic        rd_en;
  logic [4:0]  read_red_addr_req;
  logic        read_valid;
  logic [31:0] read_value;
  logic [4:0]  rat_arch_idx;
  logic [5:0]  rat_phys_idx;
  logic        prf_req;
  logic [5:0]  prf_addr;
  logic        prf_gnt;
  logic [31:0] prf_rdata = 32'hBAD0_BAD0;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  arch_reg_read_responder dut (
    .clk               (clk),
    .reset             (reset),
    .quiesced          (quiesced),
    .rd_en             (rd_en),
    .read_red_addr_req (read_red_addr_req),
    .read_valid        (read_valid),
    .read_value        (read_value),
    .rat_arch_idx      (rat_arch_idx),
    .rat_phys_idx      (rat_phys_idx),
    .prf_req           (prf_req),
    .prf_addr          (prf_addr),
    .prf_gnt           (prf_gnt),
    .prf_rdata         (prf_rdata),
    .dbg_state         (dbg_state)
  );

  // ---------------- RAT / PRF models ----------------
  logic [5:0]  rat_mem [32];
  logic [31:0] prf_mem [64];
  int stall_target = 0;
  int stall_cnt    = 0;
  int pulse_cnt    = 0;
  int prf_req_cnt  = 0;

  assign rat_phys_idx = rat_mem[rat_arch_idx];
  assign prf_gnt      = prf_req && (stall_cnt >= stall_target);

  always @(posedge clk) begin
    stall_cnt <= prf_req ? stall_cnt + 1 : 0;
    if (prf_req && prf_gnt) prf_rdata <= prf_mem[prf_addr];
    else                    prf_rdata <= 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (read_valid === 1'b1) pulse_cnt++;
    if (prf_req === 1'b1)    prf_req_cnt++;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver ----------------
  // Issues a request at the current negedge. lat is the edge offset (counted
  // from the accept edge) after which read_valid was seen, or -1 on timeout.
  // rd_en is then held for `hold` more cycles and dropped for one edge.
  task automatic run_req(input logic [4:0] idx, input int hold, output int lat,
                         output int req_cycles, output bit addr_stable, output int extra);
    logic [5:0] first_addr;
    bit seen;
    first_addr = '0;
    seen = 0;
    rd_en = 1'b1;
    read_red_addr_req = idx;
    lat = -1;
    req_cycles = 0;
    addr_stable = 1;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (prf_req === 1'b1) begin
        if (!seen) begin
          first_addr = prf_addr;
          seen = 1;
        end else if (prf_addr !== first_addr) begin
          addr_stable = 0;
        end
        req_cycles++;
      end
      if (read_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (read_valid === 1'b1) extra++;
    end
    rd_en = 1'b0;
    @(negedge clk);
    if (read_valid === 1'b1) extra++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, reqc, extra, p0;
    bit stable, found;
    logic [31:0] exp_v;

    for (int i = 0; i < 32; i++) rat_mem[i] = 6'(i);
    for (int i = 0; i < 64; i++) prf_mem[i] = 32'h5A5A_0000 | 32'(i);

    reset = 1'b0;
    quiesced = 1'b1;
    rd_en = 1'b0;
    read_red_addr_req = '0;
    repeat (3) @(negedge clk);
    check("reset_read_valid", 32'(read_valid), 32'd0);
    check("reset_read_value", read_value, 32'd0);
    check("reset_prf_req", 32'(prf_req), 32'd0);
    check("reset_prf_addr", 32'(prf_addr), 32'd0);
    check("reset_rat_idx", 32'(rat_arch_idx), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: x5 -> p37 = DEADBEEF, immediate grant
    rat_mem[5] = 6'd37;
    prf_mem[37] = 32'hDEAD_BEEF;
    stall_target = 0;
    run_req(5'd5, 0, lat, reqc, stable, extra);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_value", read_value, 32'hDEAD_BEEF);
    check("t1_prf_addr", 32'(prf_addr), 32'd37);
    check("t1_req_cycles", 32'(reqc), 32'd1);
    check("t1_single_pulse", 32'(extra), 32'd0);

    // 2: x0 reads zero with no PRF access
    rat_mem[0] = 6'd10;
    prf_mem[10] = 32'h0000_1234;
    prf_req_cnt = 0;
    run_req(5'd0, 0, lat, reqc, stable, extra);
    check("t2_latency", 32'(lat), 32'd1);
    check("t2_value", read_value, 32'd0);
    check("t2_no_prf_req", 32'(prf_req_cnt), 32'd0);

    // 3: grant withheld for 3 cycles
    rat_mem[12] = 6'd50;
    prf_mem[50] = 32'h0BAD_F00D;
    stall_target = 3;
    run_req(5'd12, 0, lat, reqc, stable, extra);
    check("t3_latency", 32'(lat), 32'd7);
    check("t3_value", read_value, 32'h0BAD_F00D);
    check("t3_req_cycles", 32'(reqc), 32'd4);
    check("t3_addr_stable", 32'(stable), 32'd1);
    check("t3_prf_addr", 32'(prf_addr), 32'd50);
    stall_target = 0;

    // 4: rd_en held past the pulse -> exactly one pulse, then a clean re-accept
    rat_mem[7] = 6'd3;
    prf_mem[3] = 32'h7777_0003;
    run_req(5'd7, 5, lat, reqc, stable, extra);
    check("t4_latency", 32'(lat), 32'd4);
    check("t4_extra_pulses", 32'(extra), 32'd0);
    run_req(5'd7, 0, lat, reqc, stable, extra);
    check("t4_reaccept_latency", 32'(lat), 32'd4);
    check("t4_reaccept_value", read_value, 32'h7777_0003);

    // 5: not quiesced -> request ignored
    rat_mem[9] = 6'd20;
    prf_mem[20] = 32'h9999_0020;
    quiesced = 1'b0;
    rd_en = 1'b1;
    read_red_addr_req = 5'd9;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg_state !== 3'd0 || prf_req !== 1'b0 || read_valid !== 1'b0) found = 1;
    end
    check("t5_idle_while_busy", 32'(found), 32'd0);
    quiesced = 1'b1;
    run_req(5'd9, 0, lat, reqc, stable, extra);
    check("t5_latency", 32'(lat), 32'd4);
    check("t5_value", read_value, 32'h9999_0020);

    // 6: reset during PRF_REQ
    rat_mem[11] = 6'd44;
    prf_mem[44] = 32'h4444_0044;
    stall_target = 100;
    rd_en = 1'b1;
    read_red_addr_req = 5'd11;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prf_req === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("t6_reached_prf_req", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_prf_req_cleared", 32'(prf_req), 32'd0);
    check("t6_read_valid_low", 32'(read_valid), 32'd0);
    check("t6_read_value_zero", read_value, 32'd0);
    check("t6_state_idle", 32'(dbg_state), 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    stall_target = 0;
    @(negedge clk);
    run_req(5'd11, 0, lat, reqc, stable, extra);
    check("t6_after_latency", 32'(lat), 32'd4);
    check("t6_after_value", read_value, 32'h4444_0044);

    // 7: full dump x0..x31 with a shifted RAT mapping
    for (int i = 0; i < 32; i++) begin
      rat_mem[i] = 6'(32 + i);
      prf_mem[32 + i] = 32'hC0DE_0000 + 32'(i);
    end
    p0 = pulse_cnt;
    for (int i = 0; i < 32; i++) begin
      exp_v = (i == 0) ? 32'd0 : (32'hC0DE_0000 + 32'(i));
      run_req(5'(i), 0, lat, reqc, stable, extra);
      check($sformatf("t7_value_x%0d", i), read_value, exp_v);
      check($sformatf("t7_latency_x%0d", i), 32'(lat), (i == 0) ? 32'd1 : 32'd4);
    end
    check("t7_pulse_count", 32'(pulse_cnt - p0), 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
